bht_port_scheduler: RTL and testbench

- Sequences a single-port, synchronous-read 2-bit-counter BHT array, sharing its one port between Fetch-stage prediction reads and EX-stage counter updates.
- Sweeps the array to Weak Not Taken after reset.
- Buffers EX updates in a small FIFO and performs read-modify-write (RMW) saturating updates.
- Sits between the fetch PC mux, the EX branch-resolution logic and the BHT RAM macro.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_update_fifo.sv | 72 +++++++
 rtl/bht_port_scheduler.sv | 166 ++++++++++++++++
 tb/tb_bht_port_scheduler.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the BHT port scheduler: counter encodings,
// scheduler state type and the saturating 2-bit counter update.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RMW_RD,
        S_RMW_WAIT,
        S_RMW_WR
    } sched_state_e;

    // Taken moves toward ST, not-taken toward SNT; both ends saturate.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == ST) ? ST : cnt + 2'd1;
        end else begin
            res = (cnt == SNT) ? SNT : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO holding resolved-branch updates ({index, taken}).
// Push is ignored when full, pop is ignored when empty.
module bp_update_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of 2).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control registers; reset drops all stored entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/bht_port_scheduler.sv
// Arbitrates the single synchronous-read BHT port between Fetch prediction
// reads and buffered EX read-modify-write counter updates, after sweeping
// the array to INIT_STATE out of reset.
module bht_port_scheduler
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES    = 64,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [1:0]  INIT_STATE = WNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_fetch_req,
    input  logic [31:0]      i_fetch_pc,
    output logic             o_fetch_gnt,
    output logic             o_pred_valid,
    output logic             o_pred_taken,
    input  logic             i_upd_valid,
    output logic             o_upd_ready,
    input  logic [31:0]      i_upd_pc,
    input  logic             i_upd_taken,
    output logic             o_bht_en,
    output logic             o_bht_we,
    output logic [IDX_W-1:0] o_bht_addr,
    output logic [1:0]       o_bht_wdata,
    input  logic [1:0]       i_bht_rdata,
    output logic             o_init_done
);

    localparam int unsigned FW    = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             init_done_q;
    logic             pred_valid_q;

    logic             bht_en, bht_we, fetch_gnt, fifo_pop;
    logic [IDX_W-1:0] bht_addr;
    logic [1:0]       bht_wdata;

    logic [IDX_W-1:0] fetch_idx;
    logic             fifo_full, fifo_empty, fifo_push;
    logic [FW-1:0]    fifo_din, fifo_dout;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic [CNT_W-1:0] fifo_count_unused;
    logic             pc_bits_unused;

    assign fetch_idx      = i_fetch_pc[IDX_W+1:2];
    assign pc_bits_unused = ^{i_fetch_pc[31:IDX_W+2], i_fetch_pc[1:0],
                              i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};

    assign o_upd_ready = rst_n && !fifo_full;
    assign fifo_push   = i_upd_valid && o_upd_ready;
    assign fifo_din    = {i_upd_pc[IDX_W+1:2], i_upd_taken};
    assign head_idx    = fifo_dout[FW-1:1];
    assign head_taken  = fifo_dout[0];

    bp_update_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    // Next-state and port control: sweep, then full-FIFO > Fetch > pending-update priority.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        cnt_d     = cnt_q;
        bht_en    = 1'b0;
        bht_we    = 1'b0;
        bht_addr  = '0;
        bht_wdata = '0;
        fetch_gnt = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state_q)
            S_INIT: begin
                bht_en    = 1'b1;
                bht_we    = 1'b1;
                bht_addr  = sweep_q;
                bht_wdata = INIT_STATE;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (fifo_full) begin
                    state_d = S_RMW_RD;
                end else if (i_fetch_req) begin
                    fetch_gnt = 1'b1;
                    bht_en    = 1'b1;
                    bht_addr  = fetch_idx;
                end else if (!fifo_empty) begin
                    state_d = S_RMW_RD;
                end
            end
            S_RMW_RD: begin
                bht_en   = 1'b1;
                bht_addr = head_idx;
                state_d  = S_RMW_WAIT;
            end
            S_RMW_WAIT: begin
                // Port is free while the RMW read data returns, so Fetch may use it.
                cnt_d = i_bht_rdata;
                if (i_fetch_req) begin
                    fetch_gnt = 1'b1;
                    bht_en    = 1'b1;
                    bht_addr  = fetch_idx;
                end
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                bht_en    = 1'b1;
                bht_we    = 1'b1;
                bht_addr  = head_idx;
                bht_wdata = sat_update(cnt_q, head_taken);
                fifo_pop  = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Scheduler state, sweep index, captured counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            sweep_q      <= '0;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            pred_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            cnt_q        <= cnt_d;
            init_done_q  <= init_done_q || (state_q != S_INIT);
            pred_valid_q <= fetch_gnt;
        end
    end

    // Combinational port outputs are held at 0 while reset is asserted.
    assign o_bht_en     = rst_n && bht_en;
    assign o_bht_we     = rst_n && bht_we;
    assign o_bht_addr   = rst_n ? bht_addr : '0;
    assign o_bht_wdata  = rst_n ? bht_wdata : '0;
    assign o_fetch_gnt  = rst_n && fetch_gnt;
    assign o_pred_valid = pred_valid_q;
    assign o_pred_taken = pred_valid_q && i_bht_rdata[1];
    assign o_init_done  = init_done_q;

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Self-checking bench for bht_port_scheduler with a behavioural BHT RAM and
// an arithmetic counter model kept per index.
module tb_bht_port_scheduler;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_fetch_req = 1'b0;
    logic [31:0]      i_fetch_pc = '0;
    logic             o_fetch_gnt, o_pred_valid, o_pred_taken;
    logic             i_upd_valid = 1'b0;
    logic             o_upd_ready;
    logic [31:0]      i_upd_pc = '0;
    logic             i_upd_taken = 1'b0;
    logic             o_bht_en, o_bht_we;
    logic [IDX_W-1:0] o_bht_addr;
    logic [1:0]       o_bht_wdata;
    logic [1:0]       rdata_q = 2'b00;
    logic             o_init_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        bit taken;
    } upd_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic [1:0] ram [ENTRIES];
    int         exp_cnt [ENTRIES];
    upd_t       pending [$];
    wr_t        wr_log [$];

    always #5 clk = ~clk;

    bht_port_scheduler #(
        .ENTRIES    (64),
        .IDX_W      (6),
        .FIFO_DEPTH (4),
        .INIT_STATE (2'b01)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fetch_req  (i_fetch_req),
        .i_fetch_pc   (i_fetch_pc),
        .o_fetch_gnt  (o_fetch_gnt),
        .o_pred_valid (o_pred_valid),
        .o_pred_taken (o_pred_taken),
        .i_upd_valid  (i_upd_valid),
        .o_upd_ready  (o_upd_ready),
        .i_upd_pc     (i_upd_pc),
        .i_upd_taken  (i_upd_taken),
        .o_bht_en     (o_bht_en),
        .o_bht_we     (o_bht_we),
        .o_bht_addr   (o_bht_addr),
        .o_bht_wdata  (o_bht_wdata),
        .i_bht_rdata  (rdata_q),
        .o_init_done  (o_init_done)
    );

    // Single-port synchronous-read RAM behaviour.
    always @(posedge clk) begin
        if (o_bht_en) begin
            if (o_bht_we) ram[o_bht_addr] <= o_bht_wdata;
            else          rdata_q <= ram[o_bht_addr];
        end
    end

    // Log every array write for later comparison.
    always @(posedge clk) begin
        if (o_bht_en && o_bht_we) begin
            wr_t w;
            w.addr = int'(o_bht_addr);
            w.data = int'(o_bht_wdata);
            wr_log.push_back(w);
        end
    end

    function automatic int model_next(int c, bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int pc_index(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic send_upd(input logic [31:0] pc, input bit t, output bit ok);
        bit acc;
        upd_t u;
        ok = 1'b0;
        @(posedge clk); #1;
        i_upd_valid = 1'b1;
        i_upd_pc    = pc;
        i_upd_taken = t;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            acc = o_upd_ready;
            @(posedge clk); #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        i_upd_valid = 1'b0;
        if (ok) begin
            u.idx = pc_index(pc);
            u.taken = t;
            pending.push_back(u);
        end
    endtask

    task automatic wait_writes(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (wr_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 i_upd_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({o_bht_en, o_bht_we, o_bht_addr, o_bht_wdata, o_fetch_gnt, o_pred_valid,
             o_pred_taken, o_upd_ready, o_init_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b we=%b addr=%0d wd=%0d gnt=%b pv=%b pt=%b rdy=%b done=%b want all 0",
                     o_bht_en, o_bht_we, o_bht_addr, o_bht_wdata, o_fetch_gnt, o_pred_valid,
                     o_pred_taken, o_upd_ready, o_init_done);
        end
        i_upd_valid = 1'b0;
    endtask

    task automatic test_init();
        for (int i = 0; i < ENTRIES; i++) ram[i] = 2'($urandom);
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_fetch_req = 1'b1;
        for (int k = 0; k < ENTRIES; k++) begin
            i_fetch_pc = $urandom;
            @(negedge clk);
            total++;
            if (o_bht_en !== 1'b1 || o_bht_we !== 1'b1 || int'(o_bht_addr) != k ||
                o_bht_wdata !== 2'b01 || o_fetch_gnt !== 1'b0) begin
                bad++;
                $display("FAIL init_sweep[%0d]: got en=%b we=%b addr=%0d wd=%b gnt=%b want 1 1 %0d 01 0",
                         k, o_bht_en, o_bht_we, o_bht_addr, o_bht_wdata, o_fetch_gnt, k);
            end
            total++;
            if (o_init_done !== 1'b0) begin
                bad++;
                $display("FAIL init_done_early[%0d]: got %b want 0", k, o_init_done);
            end
            @(posedge clk); #1;
        end
        i_fetch_req = 1'b0;
        @(negedge clk);
        total++;
        if (o_bht_en !== 1'b0 || o_init_done !== 1'b0) begin
            bad++;
            $display("FAIL init_cycle64: got en=%b done=%b want 0 0", o_bht_en, o_init_done);
        end
        @(negedge clk);
        total++;
        if (o_init_done !== 1'b1) begin
            bad++;
            $display("FAIL init_done: got %b want 1", o_init_done);
        end
        for (int i = 0; i < ENTRIES; i++) exp_cnt[i] = 1;
        for (int i = 0; i < ENTRIES; i++) begin
            total++;
            if (ram[i] !== 2'b01) begin
                bad++;
                $display("FAIL init_ram[%0d]: got %b want 01", i, ram[i]);
            end
        end
        wr_log.delete();
    endtask

    task automatic test_fetch(input int n, input bit fixed);
        bit prev_req = 1'b0;
        int prev_idx = 0;
        bit req;
        int idx;
        for (int c = 0; c <= n; c++) begin
            @(posedge clk); #1;
            req = (c == n) ? 1'b0 : (fixed ? 1'b1 : 1'($urandom_range(0, 1)));
            i_fetch_req = req;
            i_fetch_pc  = fixed ? 32'h0000_0010 : $urandom;
            idx = pc_index(i_fetch_pc);
            @(negedge clk);
            total++;
            if (req && (o_fetch_gnt !== 1'b1 || o_bht_en !== 1'b1 || o_bht_we !== 1'b0 ||
                        int'(o_bht_addr) != idx)) begin
                bad++;
                $display("FAIL fetch_grant: got gnt=%b en=%b we=%b addr=%0d want 1 1 0 %0d",
                         o_fetch_gnt, o_bht_en, o_bht_we, o_bht_addr, idx);
            end else if (!req && (o_fetch_gnt !== 1'b0 || o_bht_en !== 1'b0)) begin
                bad++;
                $display("FAIL fetch_idle: got gnt=%b en=%b want 0 0", o_fetch_gnt, o_bht_en);
            end
            total++;
            if (o_pred_valid !== prev_req ||
                o_pred_taken !== (prev_req ? (exp_cnt[prev_idx] >= 2) : 1'b0)) begin
                bad++;
                $display("FAIL fetch_pred: got valid=%b taken=%b want %b %b (idx %0d)",
                         o_pred_valid, o_pred_taken, prev_req,
                         prev_req ? (exp_cnt[prev_idx] >= 2) : 1'b0, prev_idx);
            end
            prev_req = req;
            prev_idx = idx;
        end
        i_fetch_req = 1'b0;
    endtask

    task automatic test_update();
        bit ok;
        logic [31:0] pcs [7];
        bit          tks [7];
        int          want [7];
        upd_t        u;
        wr_t         w;
        int          e;
        pcs = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h20, 32'h20, 32'h20};
        tks = '{1, 1, 1, 1, 0, 0, 0};
        want = '{2, 3, 3, 3, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            send_upd(pcs[i], tks[i], ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL upd_accept[%0d]: got no ready want ready", i);
            end
        end
        wait_writes(7, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL upd_timeout: got %0d writes want 7", wr_log.size());
        end
        for (int i = 0; i < 7; i++) begin
            if (pending.size() == 0 || wr_log.size() == 0) break;
            u = pending.pop_front();
            w = wr_log.pop_front();
            e = model_next(exp_cnt[u.idx], u.taken);
            exp_cnt[u.idx] = e;
            total++;
            if (w.addr != u.idx || w.data != e || e != want[i]) begin
                bad++;
                $display("FAIL upd_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                         i, w.addr, w.data, u.idx, want[i]);
            end
        end
        pending.delete();
    endtask

    task automatic test_random_updates();
        bit ok;
        int n = 12;
        upd_t u;
        wr_t w;
        int e;
        for (int i = 0; i < n; i++) begin
            send_upd({$urandom_range(0, 255), 19'd0, 3'($urandom_range(0, 7)), 2'b00},
                     1'($urandom_range(0, 1)), ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rnd_accept[%0d]: got no ready want ready", i);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_writes(pending.size(), ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rnd_timeout: got %0d writes want %0d", wr_log.size(), pending.size());
        end
        while (pending.size() > 0 && wr_log.size() > 0) begin
            u = pending.pop_front();
            w = wr_log.pop_front();
            e = model_next(exp_cnt[u.idx], u.taken);
            exp_cnt[u.idx] = e;
            total++;
            if (w.addr != u.idx || w.data != e) begin
                bad++;
                $display("FAIL rnd_write: got addr=%0d data=%0d want addr=%0d data=%0d",
                         w.addr, w.data, u.idx, e);
            end
        end
        pending.delete();
    endtask

    task automatic test_back_to_back();
        upd_t us [5];
        upd_t u;
        wr_t  w;
        int   k = 0;
        int   run = 0;
        int   maxrun = 0;
        int   e;
        bit   checked = 1'b0;
        bit   ok;
        for (int i = 0; i < 5; i++) begin
            us[i].idx = (i % 2 == 0) ? 20 : $urandom_range(21, 30);
            us[i].taken = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        i_fetch_req = 1'b1;
        for (int c = 0; c < 80; c++) begin
            i_fetch_pc  = $urandom;
            i_upd_valid = (k < 5);
            i_upd_pc    = (k < 5) ? 32'(us[k].idx << 2) : '0;
            i_upd_taken = (k < 5) ? us[k].taken : 1'b0;
            @(negedge clk);
            if (k == 4 && !checked) begin
                checked = 1'b1;
                total++;
                if (o_upd_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_ready_drop: got %b want 0 after 4 accepts", o_upd_ready);
                end
            end
            if (!o_fetch_gnt) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
            if (k < 5 && o_upd_ready) begin
                pending.push_back(us[k]);
                k++;
            end
            @(posedge clk); #1;
            if (k == 5 && c > 30) break;
        end
        i_upd_valid = 1'b0;
        i_fetch_req = 1'b0;
        total++;
        if (k != 5) begin
            bad++;
            $display("FAIL b2b_accepts: got %0d want 5", k);
        end
        total++;
        if (maxrun < 1 || maxrun > 2) begin
            bad++;
            $display("FAIL b2b_fetch_loss: got max lost run %0d want 1..2", maxrun);
        end
        wait_writes(pending.size(), ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_timeout: got %0d writes want %0d", wr_log.size(), pending.size());
        end
        while (pending.size() > 0 && wr_log.size() > 0) begin
            u = pending.pop_front();
            w = wr_log.pop_front();
            e = model_next(exp_cnt[u.idx], u.taken);
            exp_cnt[u.idx] = e;
            total++;
            if (w.addr != u.idx || w.data != e) begin
                bad++;
                $display("FAIL b2b_write: got addr=%0d data=%0d want addr=%0d data=%0d",
                         w.addr, w.data, u.idx, e);
            end
        end
        pending.delete();
    endtask

    task automatic test_reset_mid();
        bit seen_rd = 1'b0;
        int k = 0;
        @(posedge clk); #1;
        i_fetch_req = 1'b0;
        for (int c = 0; c < 20 && !seen_rd; c++) begin
            i_upd_valid = 1'b1;
            i_upd_pc    = 32'((40 + k) << 2);
            i_upd_taken = 1'b1;
            @(negedge clk);
            if (o_bht_en && !o_bht_we) seen_rd = 1'b1;
            if (o_upd_ready) k++;
            @(posedge clk); #1;
        end
        i_upd_valid = 1'b0;
        total++;
        if (!seen_rd || k != 3) begin
            bad++;
            $display("FAIL midrst_setup: got rd=%b accepts=%0d want 1 3", seen_rd, k);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({o_bht_en, o_bht_we, o_bht_addr, o_bht_wdata, o_fetch_gnt, o_pred_valid,
             o_pred_taken, o_upd_ready, o_init_done} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got en=%b we=%b addr=%0d wd=%0d gnt=%b pv=%b rdy=%b done=%b want all 0",
                     o_bht_en, o_bht_we, o_bht_addr, o_bht_wdata, o_fetch_gnt, o_pred_valid,
                     o_upd_ready, o_init_done);
        end
        wr_log.delete();
        pending.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < ENTRIES; i++) begin
            @(negedge clk);
            total++;
            if (o_bht_en !== 1'b1 || o_bht_we !== 1'b1 || int'(o_bht_addr) != i ||
                o_bht_wdata !== 2'b01) begin
                bad++;
                $display("FAIL midrst_sweep[%0d]: got en=%b we=%b addr=%0d wd=%b want 1 1 %0d 01",
                         i, o_bht_en, o_bht_we, o_bht_addr, o_bht_wdata, i);
            end
        end
        @(posedge clk); #1;
        wr_log.delete();
        repeat (30) @(posedge clk);
        #1;
        total++;
        if (wr_log.size() != 0) begin
            bad++;
            $display("FAIL midrst_stale: got %0d writes want 0", wr_log.size());
        end
        total++;
        if (o_init_done !== 1'b1 || ram[40] !== 2'b01 || ram[41] !== 2'b01 || ram[42] !== 2'b01) begin
            bad++;
            $display("FAIL midrst_state: got done=%b ram40..42=%b %b %b want 1 01 01 01",
                     o_init_done, ram[40], ram[41], ram[42]);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_fetch(6, 1'b1);
        test_update();
        test_fetch(4, 1'b1);
        test_random_updates();
        test_fetch(30, 1'b0);
        test_back_to_back();
        test_fetch(20, 1'b0);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
